// File: rtl/leaderboard_pkg.sv
// leaderboard_pkg: shared types and codes for the top-3 best-time leaderboard
package leaderboard_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      SHIFT,
      ANNOUNCE
   } lb_state_e;

   // Wide all-ones pattern; truncated to TIME_W it marks an unused table slot.
   localparam logic [63:0] EMPTY_TIME = '1;

   localparam logic [2:0] DISP_R1  = 3'b100;
   localparam logic [2:0] DISP_R2  = 3'b101;
   localparam logic [2:0] DISP_R3  = 3'b110;
   localparam logic [2:0] DISP_CLR = 3'b111;

   localparam logic [1:0] SF_NONE = 2'b00;
   localparam logic [1:0] SF_FAST = 2'b01;
   localparam logic [1:0] SF_SLOW = 2'b10;

   localparam logic [1:0] MODE_TIMED = 2'b01;

endpackage

// File: rtl/lb_pulse_timer.sv
// lb_pulse_timer: fixed-length sound pulse on one of three rank channels
module lb_pulse_timer
   import leaderboard_pkg::*;
#(
   parameter int CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [1:0] sel_i,
   output logic       done_o,
   output logic [2:0] sound_o
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [2:0]    sel_q;

   // Load the counter and latch the channel on start, then count down to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sel_q <= '0;
      end else if (start_i) begin
         cnt_q <= CW'(CYCLES);
         sel_q <= 3'b001 << sel_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign done_o  = cnt_q == CW'(1);
   assign sound_o = cnt_q != '0 ? sel_q : 3'b000;

endmodule

// File: rtl/leaderboard_sequencer.sv
// leaderboard_sequencer: serial-compare insertion into a top-3 best-time table
module leaderboard_sequencer
   import leaderboard_pkg::*;
#(
   parameter int TIME_W       = 22,
   parameter int SOUND_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              time_valid,
   input  logic [TIME_W-1:0] time_in,
   input  logic [1:0]        stopwatch_mode,
   input  logic [2:0]        display_mode,
   output logic [TIME_W-1:0] leaderboard_number,
   output logic              signal_sound_1,
   output logic              signal_sound_2,
   output logic              signal_sound_3,
   output logic [2:0]        leaderboard_LED,
   output logic [1:0]        slow_or_fast,
   output logic              busy,
   output logic              dropped
);

   localparam logic [TIME_W-1:0] EMPTY = TIME_W'(EMPTY_TIME);

   lb_state_e                   state_q;
   logic [2:0][TIME_W-1:0]      e_q;
   logic [TIME_W-1:0]           cand_q;
   logic [1:0]                  idx_q;
   logic [1:0]                  pos_q;
   logic                        placed_q;
   logic [2:0]                  led_q;
   logic [1:0]                  sf_q;
   logic                        dropped_q;
   logic [TIME_W-1:0]           num_q;
   logic [TIME_W-1:0]           num_d;
   logic                        timer_done;
   logic [2:0]                  sound;

   lb_pulse_timer #(.CYCLES(SOUND_CYCLES)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(state_q == SHIFT),
      .sel_i  (pos_q),
      .done_o (timer_done),
      .sound_o(sound)
   );

   // Sequencer: accept a run, walk the ranks one per cycle, shift it in, announce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         e_q       <= {3{EMPTY}};
         cand_q    <= '0;
         idx_q     <= '0;
         pos_q     <= '0;
         placed_q  <= 1'b0;
         led_q     <= '0;
         sf_q      <= SF_NONE;
         dropped_q <= 1'b0;
      end else begin
         if (time_valid && state_q != IDLE) dropped_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (display_mode == DISP_CLR) begin
                  e_q   <= {3{EMPTY}};
                  led_q <= '0;
                  sf_q  <= SF_NONE;
               end else if (time_valid && stopwatch_mode == MODE_TIMED) begin
                  cand_q  <= time_in;
                  idx_q   <= '0;
                  state_q <= CMP;
               end
            end
            CMP: begin
               if (cand_q < e_q[idx_q]) begin
                  pos_q   <= idx_q;
                  state_q <= SHIFT;
               end else if (idx_q == 2'd2) begin
                  placed_q <= 1'b0;
                  led_q    <= '0;
                  sf_q     <= SF_SLOW;
                  state_q  <= ANNOUNCE;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
            SHIFT: begin
               e_q[0]   <= pos_q == 2'd0 ? cand_q : e_q[0];
               e_q[1]   <= pos_q == 2'd1 ? cand_q : pos_q == 2'd0 ? e_q[0] : e_q[1];
               e_q[2]   <= pos_q == 2'd2 ? cand_q : e_q[1];
               placed_q <= 1'b1;
               led_q    <= 3'b001 << pos_q;
               sf_q     <= SF_FAST;
               state_q  <= ANNOUNCE;
            end
            ANNOUNCE: begin
               if (!placed_q || timer_done) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Display source select: a rank slot, blank on clear, otherwise the live time.
   always_comb begin
      num_d = display_mode == DISP_R1  ? e_q[0] :
              display_mode == DISP_R2  ? e_q[1] :
              display_mode == DISP_R3  ? e_q[2] :
              display_mode == DISP_CLR ? '0     : time_in;
   end

   // Register the display value so the 7-segment path sees a clean, timed output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) num_q <= '0;
      else        num_q <= num_d;
   end

   assign leaderboard_number = num_q;
   assign signal_sound_1     = sound[0];
   assign signal_sound_2     = sound[1];
   assign signal_sound_3     = sound[2];
   assign leaderboard_LED    = led_q;
   assign slow_or_fast       = sf_q;
   assign busy               = state_q != IDLE;
   assign dropped            = dropped_q;

endmodule
